ysyx_24070016_wb_arbiter: RTL
=============================

Name: ysyx_24070016_wb_arbiter

Overview:
- Write-back front end for the integer register file. Two producers compete for the single register-file write port: EXU (ALU results) and LSU (load data).
- Arbitrates between them with valid/ready handshakes and drives a registered write port (wen/waddr/wdata).
- Keeps a per-register busy scoreboard (set at issue, cleared at write commit). IDU uses it for RAW hazard stalls.

Parameters:
- ADDR_WIDTH, 5, register index width; register count is 2**ADDR_WIDTH.
- DATA_WIDTH, 32, register data width.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset; asynchronous, active-high.
- exu_valid  in  1  EXU has a result to write back.
- exu_ready  out  1  EXU result accepted this cycle.
- exu_rd  in  ADDR_WIDTH  EXU destination register.
- exu_data  in  DATA_WIDTH  EXU result.
- lsu_valid  in  1  LSU has load data to write back.
- lsu_ready  out  1  LSU data accepted this cycle.
- lsu_rd  in  ADDR_WIDTH  LSU destination register.
- lsu_data  in  DATA_WIDTH  LSU load data.
- iss_valid  in  1  an instruction with a destination register issues this cycle.
- iss_rd  in  ADDR_WIDTH  destination of the issuing instruction.
- rf_wen  out  1  register-file write enable.
- rf_waddr  out  ADDR_WIDTH  register-file write address.
- rf_wdata  out  DATA_WIDTH  register-file write data.
- busy  out  2**ADDR_WIDTH  busy[i]=1 means register i has a write pending.

Behaviour:
- Reset (async, rst=1) sets:
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - busy=all 0.
  - round-robin pointer = LSU-preferred.
  - exu_ready/lsu_ready = 0 while rst is high.
- Handshake:
  - A transfer occurs on a posedge where valid && ready for a source.
  - A source holds valid, rd and data stable until its ready. It must not drop valid before the handshake.
- Ready generation:
  - Ready is combinational from valid and the pointer (the grant). There is no downstream backpressure.
  - At most one of exu_ready/lsu_ready is high in any cycle.
- Arbitration:
  - Only one source valid: that source is granted.
  - Both valid: the source named by the pointer is granted.
  - Pointer update: after a conflict cycle, the pointer flips to the non-granted source. With no conflict, the pointer is unchanged.
  - Result: under continuous contention, grants alternate LSU, EXU, LSU, ...
- Write port (one-cycle latency), on the posedge of a handshake:
  - rf_waddr and rf_wdata load the granted rd/data.
  - rf_wen loads (rd != 0).
  - No handshake: rf_wen=0; rf_waddr/rf_wdata hold their previous values.
- rd = 0: the handshake completes normally and rf_wen stays 0. x0 is never written and never marked busy.
- Scoreboard:
  - Set: on a posedge with iss_valid && iss_rd != 0, busy[iss_rd] becomes 1.
  - Clear: on a posedge where rf_wen=1, busy[rf_waddr] becomes 0 (the commit cycle).
  - Same index set and cleared on one edge: set wins (a new producer is in flight).
  - Different indices on one edge: both updates apply.
  - busy[0] is constant 0.
- Throughput: one write-back per cycle sustained.
  - Latency from handshake edge to rf_wen high: 1 cycle.
  - Latency to busy clear: 2 edges after the handshake.
- Reset mid-operation: outputs return to reset values immediately. Pending busy bits are discarded, and in-flight handshakes are lost; the upstream re-issues.
- Out-of-range or X inputs while valid=0 are ignored.

Test Plan:
1. Reset then idle → rf_wen=0, busy=0, both readys 0; after rst deasserts with no valid, readys stay 0.
2. EXU alone: exu_valid=1, exu_rd=5, exu_data=0x1234 → exu_ready=1 same cycle; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234; following cycle rf_wen=0.
3. Contention, both valid for 4 cycles (LSU rd=3, EXU rd=4, distinct data each transfer) → grant order LSU, EXU, LSU, EXU; rf_waddr sequence 3,4,3,4 with matching data; never two readys in one cycle.
4. Scoreboard:
   - iss_valid with iss_rd=7 → busy[7]=1 next cycle.
   - Later LSU write to rd=7 → busy[7] clears on the edge after rf_wen.
   - iss_rd=7 issued on the same edge as the clear → busy[7] stays 1.
5. rd=0: EXU writes rd=0 with data 0xFFFFFFFF, and iss_valid with iss_rd=0 → handshake completes; rf_wen stays 0 and busy[0] stays 0.
6. Async reset asserted mid-transfer while busy[9]=1 and rf_wen=1 → rf_wen, busy and readys drop to 0 without a clock edge; after release, pointer favours LSU.

Source files
------------

// File: rtl/ysyx_24070016_wb_arbiter.sv
// Write-back arbiter: EXU/LSU compete for one registered register-file write port.
// Also keeps a per-register busy scoreboard that IDU reads for RAW hazard stalls.
module ysyx_24070016_wb_arbiter #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       exu_valid,
  output logic                       exu_ready,
  input  logic [ADDR_WIDTH-1:0]      exu_rd,
  input  logic [DATA_WIDTH-1:0]      exu_data,
  input  logic                       lsu_valid,
  output logic                       lsu_ready,
  input  logic [ADDR_WIDTH-1:0]      lsu_rd,
  input  logic [DATA_WIDTH-1:0]      lsu_data,
  input  logic                       iss_valid,
  input  logic [ADDR_WIDTH-1:0]      iss_rd,
  output logic                       rf_wen,
  output logic [ADDR_WIDTH-1:0]      rf_waddr,
  output logic [DATA_WIDTH-1:0]      rf_wdata,
  output logic [(2**ADDR_WIDTH)-1:0] busy
);

  localparam int unsigned NumRegs = 2 ** ADDR_WIDTH;

  typedef enum logic {
    PrefLsu = 1'b0,
    PrefExu = 1'b1
  } pref_e;

  pref_e                  ptr_q, ptr_d;
  logic                   exu_gnt, lsu_gnt;
  logic [ADDR_WIDTH-1:0]  sel_rd;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [NumRegs-1:0]     busy_q, busy_d;

  always_comb begin
    exu_gnt = exu_valid && (!lsu_valid || (ptr_q == PrefExu));
    lsu_gnt = lsu_valid && !exu_gnt;
    // Ready must stay low for the whole time reset is held, not just after an edge.
    exu_ready = exu_gnt && !rst;
    lsu_ready = lsu_gnt && !rst;
    sel_rd    = exu_gnt ? exu_rd   : lsu_rd;
    sel_data  = exu_gnt ? exu_data : lsu_data;
    ptr_d     = ptr_q;
    if (exu_valid && lsu_valid) begin
      ptr_d = exu_gnt ? PrefLsu : PrefExu;
    end
  end

  always_comb begin
    busy_d = busy_q;
    if (rf_wen) begin
      busy_d[rf_waddr] = 1'b0;
    end
    // Applied after the clear so a re-issue on the commit edge keeps the bit set.
    if (iss_valid && (iss_rd != '0)) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q    <= PrefLsu;
      busy_q   <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      ptr_q  <= ptr_d;
      busy_q <= busy_d;
      if (exu_gnt || lsu_gnt) begin
        rf_wen   <= (sel_rd != '0);
        rf_waddr <= sel_rd;
        rf_wdata <= sel_data;
      end else begin
        rf_wen <= 1'b0;
      end
    end
  end

  assign busy = busy_q;

endmodule
